align_ctrl: RTL and testbench

Link-bring-up sequencer for the 64-bit word aligner in the BER receive path. It pulses the aligner's PHY_INIT, waits for ALIGNED, then checks that the sync word 64'hF731_8CEF_137F_FEC8 recurs every FRAME_LEN aligned words before it declares LINK_UP. While locked it keeps checking the sync position, and it retries or fails under a bounded retry budget. It sits between the aligner outputs (DOPUSH/DOUT/ALIGNED) and the BER checker, which consumes data only while LINK_UP is high.

---
 rtl/align_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_align_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/align_ctrl.sv
// Link bring-up sequencer for the 64-bit word aligner: PHY init pulse, sync hunt,
// frame verification and lock supervision. Optional macro: ALIGN_CTRL_AUTO_RELOCK_EN.
module align_ctrl #(
  parameter int INIT_CYC  = 16,
  parameter int HUNT_TO   = 1024,
  parameter int FRAME_LEN = 64,
  parameter int VERIFY_N  = 4,
  parameter int LOSS_N    = 3,
  parameter int MAX_RETRY = 7
) (
  input  logic        CLK,
  input  logic        RSTX,
  input  logic        START,
  input  logic        ALIGNED,
  input  logic        DVALID,
  input  logic [63:0] DIN,
  output logic        PHY_INIT,
  output logic        LINK_UP,
  output logic        FAIL,
  output logic        SYNC_ERR,
  output logic [7:0]  RETRY,
  output logic [2:0]  STATE_DBG
);

  localparam logic [63:0] SYNC_WORD = 64'hF731_8CEF_137F_FEC8;
  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int IW = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

  localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_CYC - 1);
  localparam logic [10:0]   HUNT_LAST  = 11'(HUNT_TO - 1);
  localparam logic [PW-1:0] POS_LAST   = PW'(FRAME_LEN - 1);
  localparam logic [PW-1:0] POS_ONE    = PW'(1);
  localparam logic [3:0]    VERIFY_CNT = 4'(VERIFY_N);
  localparam logic [3:0]    LOSS_CNT   = 4'(LOSS_N);
  localparam logic [7:0]    RETRY_MAX  = 8'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_HUNT   = 3'd2,
    S_VERIFY = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5,
    S_LOST   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] init_q, init_d;
  logic [10:0]   hunt_q, hunt_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [3:0]    good_q, good_d;
  logic [3:0]    miss_q, miss_d;
  logic [7:0]    retry_q, retry_d;
  logic          sync_err_d;
  logic          attempt_fail;
  logic          loss;
  logic          sync_hit;
  logic          frame_chk;
  logic [PW-1:0] pos_inc;
  logic [7:0]    retry_inc;

  // DVALID is a valid-only qualifier (the aligner cannot be stalled): a word is
  // consumed on every cycle with DVALID=1, and DIN is don't-care otherwise.
  assign sync_hit  = DVALID && (DIN == SYNC_WORD);
  assign frame_chk = DVALID && (pos_q == '0);
  assign pos_inc   = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
  assign retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    init_d       = init_q;
    hunt_d       = hunt_q;
    pos_d        = pos_q;
    good_d       = good_q;
    miss_d       = miss_q;
    retry_d      = retry_q;
    sync_err_d   = 1'b0;
    attempt_fail = 1'b0;
    loss         = 1'b0;

    if (START) begin
      state_d = S_INIT;
      init_d  = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_INIT: begin
          if (init_q == INIT_LAST) begin
            state_d = S_HUNT;
            hunt_d  = '0;
          end else begin
            init_d = init_q + 1'b1;
          end
        end
        S_HUNT: begin
          if (DVALID) begin
            if (ALIGNED && sync_hit) begin
              state_d = S_VERIFY;
              pos_d   = POS_ONE;
              good_d  = 4'd1;
            end else if (hunt_q == HUNT_LAST) begin
              attempt_fail = 1'b1;
            end else begin
              hunt_d = hunt_q + 11'd1;
            end
          end
        end
        S_VERIFY: begin
          if (!ALIGNED) begin
            attempt_fail = 1'b1;
          end else if (DVALID) begin
            pos_d = pos_inc;
            if (frame_chk) begin
              if (sync_hit) begin
                good_d = good_q + 4'd1;
                if (good_q + 4'd1 == VERIFY_CNT) begin
                  state_d = S_LOCKED;
                  miss_d  = '0;
                end
              end else begin
                attempt_fail = 1'b1;
              end
            end
          end
        end
        S_LOCKED: begin
          if (DVALID) pos_d = pos_inc;
          if (frame_chk) begin
            if (sync_hit) begin
              miss_d = '0;
            end else begin
              miss_d     = miss_q + 4'd1;
              sync_err_d = 1'b1;
              if (miss_q + 4'd1 == LOSS_CNT) loss = 1'b1;
            end
          end
          if (!ALIGNED) loss = 1'b1;
        end
        S_FAIL: ;
`ifndef ALIGN_CTRL_AUTO_RELOCK_EN
        S_LOST: ;
`endif
        default: state_d = S_IDLE;
      endcase

      if (attempt_fail) begin
        retry_d = retry_inc;
        init_d  = '0;
        state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_INIT;
      end

      if (loss) begin
`ifdef ALIGN_CTRL_AUTO_RELOCK_EN
        state_d = S_INIT;
        init_d  = '0;
        retry_d = '0;
`else
        state_d = S_LOST;
`endif
      end
    end
  end

  // Outputs are decoded from the next state so they switch with the state register.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q  <= S_IDLE;
      init_q   <= '0;
      hunt_q   <= '0;
      pos_q    <= '0;
      good_q   <= '0;
      miss_q   <= '0;
      retry_q  <= '0;
      PHY_INIT <= 1'b0;
      LINK_UP  <= 1'b0;
      FAIL     <= 1'b0;
      SYNC_ERR <= 1'b0;
    end else begin
      state_q  <= state_d;
      init_q   <= init_d;
      hunt_q   <= hunt_d;
      pos_q    <= pos_d;
      good_q   <= good_d;
      miss_q   <= miss_d;
      retry_q  <= retry_d;
      PHY_INIT <= (state_d == S_INIT);
      LINK_UP  <= (state_d == S_LOCKED);
      FAIL     <= (state_d == S_FAIL);
      SYNC_ERR <= sync_err_d;
    end
  end

  assign RETRY     = retry_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_align_ctrl.sv
// Self-checking bench for align_ctrl: table-driven bring-up vectors plus
// hand-written retry, timeout, START-priority and reset sequences.
module tb_align_ctrl;

  localparam logic [63:0] SYNC = 64'hF731_8CEF_137F_FEC8;
  localparam int INIT_CYC  = 16;
  localparam int HUNT_TO   = 1024;
  localparam int FRAME_LEN = 64;
  localparam int MAX_RETRY = 7;

  localparam int K_RND  = 0;
  localparam int K_SYNC = 1;
  localparam int K_NEAR = 2;

  logic        CLK;
  logic        RSTX;
  logic        START;
  logic        ALIGNED;
  logic        DVALID;
  logic [63:0] DIN;
  logic        PHY_INIT;
  logic        LINK_UP;
  logic        FAIL;
  logic        SYNC_ERR;
  logic [7:0]  RETRY;
  logic [2:0]  STATE_DBG;

  align_ctrl dut (
    .CLK       (CLK),
    .RSTX      (RSTX),
    .START     (START),
    .ALIGNED   (ALIGNED),
    .DVALID    (DVALID),
    .DIN       (DIN),
    .PHY_INIT  (PHY_INIT),
    .LINK_UP   (LINK_UP),
    .FAIL      (FAIL),
    .SYNC_ERR  (SYNC_ERR),
    .RETRY     (RETRY),
    .STATE_DBG (STATE_DBG)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #10ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // scoreboard: {PHY_INIT, LINK_UP, FAIL, SYNC_ERR, RETRY}
  logic [11:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [11:0] ev(bit pi, bit lu, bit fl, bit se, logic [7:0] rt);
    return {pi, lu, fl, se, rt};
  endfunction

  function automatic logic [63:0] pick(int kind);
    logic [63:0] w;
    if (kind == K_SYNC) begin
      w = SYNC;
    end else if (kind == K_NEAR) begin
      w = SYNC ^ (64'd1 << $urandom_range(0, 63));
    end else begin
      w = {$urandom, $urandom};
      if (w == SYNC) w[0] = ~w[0];
    end
    return w;
  endfunction

  task automatic compare_now(input string nm);
    logic [11:0] got;
    logic [11:0] e;
    got = {PHY_INIT, LINK_UP, FAIL, SYNC_ERR, RETRY};
    e   = exp_q.pop_front();
    n_vec++;
    if (got !== e) begin
      n_err++;
      $display("FAIL %s: got pi=%b lu=%b fail=%b se=%b retry=%0d (state %0d), expected pi=%b lu=%b fail=%b se=%b retry=%0d at %0t",
               nm, got[11], got[10], got[9], got[8], got[7:0], STATE_DBG,
               e[11], e[10], e[9], e[8], e[7:0], $time);
    end
  endtask

  // driver: apply inputs for one cycle, expect outputs after the edge
  task automatic step(input bit s, input bit a, input bit v, input int kind,
                      input logic [11:0] e, input string nm);
    START   = s;
    ALIGNED = a;
    DVALID  = v;
    DIN     = pick(kind);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    compare_now(nm);
  endtask

  // Remaining INIT cycles after the START/fail edge, then the edge into HUNT.
  // A valid sync word on the exit edge must not count: the block is still in INIT.
  task automatic init_phase(input logic [7:0] rt);
    for (int i = 0; i < INIT_CYC - 1; i++) step(0, 1, 0, K_RND, ev(1, 0, 0, 0, rt), "init_hold");
    step(0, 1, 1, K_SYNC, ev(0, 0, 0, 0, rt), "init_exit");
  endtask

  // Sync hit in HUNT, then three frames; the last sync word locks (or carries START).
  task automatic verify_phase(input logic [7:0] rt, input bit start_last);
    step(0, 1, 1, K_SYNC, ev(0, 0, 0, 0, rt), "hunt_hit");
    for (int f = 1; f <= 3; f++) begin
      for (int i = 0; i < FRAME_LEN - 1; i++) step(0, 1, 1, K_RND, ev(0, 0, 0, 0, rt), "verify_data");
      if (f < 3) step(0, 1, 1, K_SYNC, ev(0, 0, 0, 0, rt), "verify_sync");
      else if (start_last) step(1, 1, 1, K_SYNC, ev(1, 0, 0, 0, 0), "start_vs_lock");
      else step(0, 1, 1, K_SYNC, ev(0, 1, 0, 0, rt), "lock");
    end
  endtask

  typedef struct {
    bit          start;
    bit          aligned;
    bit          dvalid;
    int          kind;
    int          reps;
    logic [11:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit s, input bit a, input bit v, input int k, input int r,
                     input logic [11:0] e, input string nm);
    vec_t t;
    t.start = s; t.aligned = a; t.dvalid = v; t.kind = k; t.reps = r; t.exp = e; t.nm = nm;
    tbl.push_back(t);
  endtask

  initial begin
    logic [11:0] e0, lk, se1;
    int n;
    e0  = ev(0, 0, 0, 0, 0);
    lk  = ev(0, 1, 0, 0, 0);
    se1 = ev(0, 1, 0, 1, 0);

    // clean-stream bring-up, lock, miss handling and loss of lock
    add(0, 1, 1, K_SYNC, 3, e0, "idle_ignores");
    add(1, 0, 0, K_RND, 1, ev(1, 0, 0, 0, 0), "start_init");
    add(0, 0, 0, K_RND, INIT_CYC - 1, ev(1, 0, 0, 0, 0), "init_hold");
    add(0, 0, 1, K_SYNC, 1, e0, "init_exit");
    add(0, 0, 1, K_SYNC, 40, e0, "hunt_unaligned_sync");
    add(0, 1, 0, K_SYNC, 4, e0, "hunt_gap");
    add(0, 1, 1, K_NEAR, 20, e0, "hunt_near_miss");
    add(0, 1, 1, K_SYNC, 1, e0, "hunt_hit");
    add(0, 1, 1, K_RND, FRAME_LEN - 2, e0, "verify_f1");
    add(0, 1, 0, K_SYNC, 3, e0, "verify_gap");
    add(0, 1, 1, K_RND, 1, e0, "verify_f1_end");
    add(0, 1, 1, K_SYNC, 1, e0, "verify_sync2");
    add(0, 1, 1, K_RND, FRAME_LEN - 1, e0, "verify_f2");
    add(0, 1, 1, K_SYNC, 1, e0, "verify_sync3");
    add(0, 1, 1, K_RND, FRAME_LEN - 1, e0, "verify_f3");
    add(0, 1, 1, K_SYNC, 1, lk, "lock_4th_sync");
    add(0, 1, 1, K_RND, FRAME_LEN - 1, lk, "locked_data");
    add(0, 1, 1, K_NEAR, 1, se1, "miss_single");
    add(0, 1, 1, K_RND, FRAME_LEN - 1, lk, "locked_data");
    add(0, 1, 1, K_SYNC, 1, lk, "miss_cleared");
    add(0, 1, 1, K_RND, FRAME_LEN - 1, lk, "locked_data");
    add(0, 1, 1, K_NEAR, 1, se1, "miss_a");
    add(0, 1, 1, K_RND, FRAME_LEN - 1, lk, "locked_data");
    add(0, 1, 1, K_NEAR, 1, se1, "miss_b");
    add(0, 1, 1, K_RND, FRAME_LEN - 1, lk, "locked_data");
`ifdef ALIGN_CTRL_AUTO_RELOCK_EN
    add(0, 1, 1, K_NEAR, 1, ev(1, 0, 0, 1, 0), "miss_loss");
    add(0, 1, 1, K_SYNC, INIT_CYC - 1, ev(1, 0, 0, 0, 0), "relock_init");
    add(0, 1, 1, K_RND, 5, e0, "relock_hunt");
`else
    add(0, 1, 1, K_NEAR, 1, ev(0, 0, 0, 1, 0), "miss_loss");
    add(0, 1, 1, K_SYNC, 20, e0, "lost_wait");
`endif

    RSTX = 1'b0; START = 1'b0; ALIGNED = 1'b0; DVALID = 1'b0; DIN = '0;
    repeat (3) @(posedge CLK);
    #1;
    exp_q.push_back(e0);
    compare_now("reset_vals");
    RSTX = 1'b1;

    foreach (tbl[i])
      for (int r = 0; r < tbl[i].reps; r++)
        step(tbl[i].start, tbl[i].aligned, tbl[i].dvalid, tbl[i].kind, tbl[i].exp, tbl[i].nm);

    // ALIGNED never asserted: every attempt times out after HUNT_TO words
    step(1, 0, 0, K_RND, ev(1, 0, 0, 0, 0), "restart");
    for (int k = 1; k <= MAX_RETRY; k++) begin
      for (int i = 0; i < INIT_CYC - 1; i++) step(0, 0, 0, K_RND, ev(1, 0, 0, 0, 8'(k - 1)), "retry_init");
      step(0, 0, 1, K_SYNC, ev(0, 0, 0, 0, 8'(k - 1)), "retry_init_exit");
      n = 0;
      while (n < HUNT_TO - 1) begin
        if ($urandom_range(0, 7) == 0) begin
          step(0, 0, 0, K_SYNC, ev(0, 0, 0, 0, 8'(k - 1)), "hunt_gap");
        end else begin
          step(0, 0, 1, K_SYNC, ev(0, 0, 0, 0, 8'(k - 1)), "hunt_count");
          n++;
        end
      end
      if (k < MAX_RETRY) step(0, 0, 1, K_SYNC, ev(1, 0, 0, 0, 8'(k)), "hunt_timeout");
      else step(0, 0, 1, K_SYNC, ev(0, 0, 1, 0, 8'(k)), "hunt_timeout_fail");
    end
    for (int i = 0; i < 5; i++) step(0, 1, 1, K_SYNC, ev(0, 0, 1, 0, 7), "fail_hold");
    step(1, 1, 1, K_SYNC, ev(1, 0, 0, 0, 0), "fail_restart");

    // sync word one position early on the second VERIFY frame
    init_phase(0);
    step(0, 1, 1, K_SYNC, ev(0, 0, 0, 0, 0), "hunt_hit");
    for (int i = 0; i < FRAME_LEN - 2; i++) step(0, 1, 1, K_RND, ev(0, 0, 0, 0, 0), "verify_data");
    step(0, 1, 1, K_SYNC, ev(0, 0, 0, 0, 0), "verify_early_sync");
    step(0, 1, 1, K_RND, ev(1, 0, 0, 0, 1), "verify_offset_fail");
    init_phase(1);
    verify_phase(1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, K_RND, ev(0, 1, 0, 0, 1), "locked_retry1");

    // START while locked, then START on the same cycle as the 4th good word
    step(1, 1, 1, K_SYNC, ev(1, 0, 0, 0, 0), "start_from_locked");
    init_phase(0);
    verify_phase(0, 1);
    init_phase(0);
    verify_phase(0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, K_RND, lk, "locked_data");

    // asynchronous reset in the middle of a cycle
    #3;
    RSTX = 1'b0;
    #1;
    exp_q.push_back(e0);
    compare_now("rstx_async");
    step(0, 1, 1, K_SYNC, e0, "rstx_held");
    RSTX = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 1, 1, K_SYNC, e0, "post_reset_idle");

    // ALIGNED dropping while locked
    step(1, 1, 0, K_RND, ev(1, 0, 0, 0, 0), "restart");
    init_phase(0);
    verify_phase(0, 0);
    step(0, 1, 1, K_RND, lk, "locked_data");
`ifdef ALIGN_CTRL_AUTO_RELOCK_EN
    step(0, 0, 0, K_RND, ev(1, 0, 0, 0, 0), "aligned_loss");
    init_phase(0);
`else
    step(0, 0, 0, K_RND, e0, "aligned_loss");
    for (int i = 0; i < 3; i++) step(0, 1, 1, K_SYNC, e0, "lost_hold");
    step(1, 1, 1, K_SYNC, ev(1, 0, 0, 0, 0), "lost_restart");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
